// File: rtl/mcu_pkg.sv
// Shared types and defaults for the MCU interrupt logic.
package mcu_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ISR  = 2'd2,
    RET  = 2'd3
  } int_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by a rising-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      last_q <= sync_q[STAGES-1];
    end
  end

  // One-cycle pulse in the cycle after the synchronized level first reads high.
  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/int_flag_ctrl.sv
// Interrupt flag controller: pending latch, I flag, C/Z shadow save/restore and
// the IDLE/REQ/ISR/RET sequencing toward the control unit.
module int_flag_ctrl
  import mcu_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       intr,
  input  logic       sei,
  input  logic       cli,
  input  logic       int_ack,
  input  logic       reti,
  input  logic       reti_en,
  input  logic       c_in,
  input  logic       z_in,
  output logic       int_req,
  output logic       i_flag,
  output logic       in_isr,
  output logic       shad_c,
  output logic       shad_z,
  output logic       flg_ld_sel,
  output logic       flg_ld,
  output logic       err_reti,
  output logic [1:0] state_dbg,
  output logic       pending_dbg
);

  int_state_t state, state_nx;
  logic       pending;
  logic       ret_ie;
  logic       rise;
  logic       take;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (intr),
    .rise  (rise)
  );

  // Control-unit inputs are single-cycle strobes sampled on the rising edge; int_req
  // is a level held in REQ until int_ack is strobed or the I flag drops.
  assign take = (state == REQ) && int_ack;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pending && i_flag) state_nx = REQ;
      REQ: begin
        if (int_ack)      state_nx = ISR;
        else if (!i_flag) state_nx = IDLE;
      end
      ISR:     if (reti) state_nx = RET;
      RET:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      i_flag   <= 1'b0;
      shad_c   <= 1'b0;
      shad_z   <= 1'b0;
      ret_ie   <= 1'b0;
      err_reti <= 1'b0;
    end else begin
      state   <= state_nx;
      // An edge landing on the acknowledge cycle survives the clear.
      pending <= (pending & ~take) | rise;
      if (take) begin
        shad_c <= c_in;
        shad_z <= z_in;
      end
      if (take)              i_flag <= 1'b0;
      else if (state == RET) i_flag <= ret_ie;
      else if (cli)          i_flag <= 1'b0;
      else if (sei)          i_flag <= 1'b1;
      // RETIE/RETID choice is captured with reti so RET need not see reti_en again.
      if ((state == ISR) && reti) ret_ie <= reti_en;
      if ((state != ISR) && reti) err_reti <= 1'b1;
    end
  end

  assign int_req     = (state == REQ);
  assign in_isr      = (state == ISR);
  assign flg_ld      = (state == RET);
  assign flg_ld_sel  = (state == RET);
  assign state_dbg   = state;
  assign pending_dbg = pending;

endmodule

// File: tb/tb_int_flag_ctrl.sv
// Directed bench for int_flag_ctrl: vector table for the main service flow plus
// hand sequences for masking, re-entry, REQ abort, RET override and mid-ISR reset.
module tb_int_flag_ctrl;

  logic clk = 1'b0, clr_n = 1'b0;
  logic intr = 1'b0, sei = 1'b0, cli = 1'b0, int_ack = 1'b0;
  logic reti = 1'b0, reti_en = 1'b0, c_in = 1'b0, z_in = 1'b0;
  logic int_req, i_flag, in_isr, shad_c, shad_z, flg_ld_sel, flg_ld, err_reti, pending_dbg;
  logic [1:0] state_dbg;
  int total = 0, bad = 0;

  // in  bits: intr sei cli ack reti reti_en c_in z_in
  // out bits: int_req i_flag in_isr shad_c shad_z flg_ld err_reti pending
  typedef struct packed {
    logic [7:0] in;
    logic [1:0] st;
    logic [7:0] out;
  } vec_t;

  vec_t vt [15];

  int_flag_ctrl #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .intr        (intr),
    .sei         (sei),
    .cli         (cli),
    .int_ack     (int_ack),
    .reti        (reti),
    .reti_en     (reti_en),
    .c_in        (c_in),
    .z_in        (z_in),
    .int_req     (int_req),
    .i_flag      (i_flag),
    .in_isr      (in_isr),
    .shad_c      (shad_c),
    .shad_z      (shad_z),
    .flg_ld_sel  (flg_ld_sel),
    .flg_ld      (flg_ld),
    .err_reti    (err_reti),
    .state_dbg   (state_dbg),
    .pending_dbg (pending_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] outs();
    return {int_req, i_flag, in_isr, shad_c, shad_z, flg_ld, err_reti, pending_dbg};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v);
    {intr, sei, cli, int_ack, reti, reti_en, c_in, z_in} = v;
  endtask

  initial begin
    vt[0]  = {8'b0100_0000, 2'd0, 8'b0100_0000}; // sei
    vt[1]  = {8'b1000_0000, 2'd0, 8'b0100_0000}; // intr high, edge 1
    vt[2]  = {8'b1000_0000, 2'd0, 8'b0100_0000}; // edge 2
    vt[3]  = {8'b1000_0000, 2'd0, 8'b0100_0001}; // edge 3: pending
    vt[4]  = {8'b1000_0000, 2'd1, 8'b1100_0001}; // edge 4: int_req
    vt[5]  = {8'b1000_0000, 2'd1, 8'b1100_0001}; // hold REQ
    vt[6]  = {8'b1001_0010, 2'd2, 8'b0011_0000}; // ack c=1 z=0
    vt[7]  = {8'b0000_0000, 2'd2, 8'b0011_0000};
    vt[8]  = {8'b0000_1100, 2'd3, 8'b0001_0100}; // RETIE -> RET
    vt[9]  = {8'b0000_0000, 2'd0, 8'b0101_0000}; // i_flag restored
    vt[10] = {8'b0000_0000, 2'd0, 8'b0101_0000};
    vt[11] = {8'b0110_0000, 2'd0, 8'b0001_0000}; // sei+cli: cli wins
    vt[12] = {8'b0000_1000, 2'd0, 8'b0001_0010}; // reti in IDLE
    vt[13] = {8'b0001_0011, 2'd0, 8'b0001_0010}; // ack in IDLE ignored
    vt[14] = {8'b0000_0000, 2'd0, 8'b0001_0010}; // err sticky

    #12;
    chk("reset_outs", outs(), 8'h00);
    chk("reset_state", {6'd0, state_dbg}, 8'd0);
    chk("reset_sel", {7'd0, flg_ld_sel}, 8'd0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].in);
      step();
      chk($sformatf("vec%0d_outs", i), outs(), vt[i].out);
      chk($sformatf("vec%0d_state", i), {6'd0, state_dbg}, {6'd0, vt[i].st});
      chk($sformatf("vec%0d_sel", i), {7'd0, flg_ld_sel}, {7'd0, vt[i].out[2]});
    end
    drive(8'h00);

    // Masked edge, later sei, then cli aborts REQ with pending kept.
    intr = 1'b1;
    repeat (4) step();
    chk("mask_pending", {7'd0, pending_dbg}, 8'd1);
    chk("mask_no_req", {7'd0, int_req}, 8'd0);
    sei = 1'b1;
    step();
    sei = 1'b0;
    chk("sei_iflag", {7'd0, i_flag}, 8'd1);
    step();
    chk("sei_req", {7'd0, int_req}, 8'd1);
    cli = 1'b1;
    step();
    cli = 1'b0;
    chk("cli_iflag", {7'd0, i_flag}, 8'd0);
    step();
    chk("abort_state", {6'd0, state_dbg}, 8'd0);
    chk("abort_pending", {7'd0, pending_dbg}, 8'd1);
    chk("abort_req", {7'd0, int_req}, 8'd0);

    // Service with c=0 z=1, second edge during ISR, RETIE re-request.
    sei = 1'b1;
    step();
    sei = 1'b0;
    step();
    chk("b_req", {7'd0, int_req}, 8'd1);
    int_ack = 1'b1; c_in = 1'b0; z_in = 1'b1;
    step();
    int_ack = 1'b0; z_in = 1'b0;
    chk("b_shadow", {6'd0, shad_c, shad_z}, 8'b01);
    chk("b_isr", {5'd0, in_isr, i_flag, pending_dbg}, 8'b100);
    intr = 1'b0;
    repeat (2) step();
    intr = 1'b1;
    repeat (4) step();
    chk("b_isr_pending", {7'd0, pending_dbg}, 8'd1);
    chk("b_isr_noreq", {7'd0, int_req}, 8'd0);
    chk("b_isr_state", {6'd0, state_dbg}, 8'd2);
    reti = 1'b1; reti_en = 1'b1;
    step();
    reti = 1'b0;
    chk("b_ret", {6'd0, flg_ld, flg_ld_sel}, 8'b11);
    step();
    reti_en = 1'b0;
    chk("b_ret_done", {5'd0, flg_ld, i_flag, 1'b0}, 8'b010);
    step();
    chk("b_rereq", {7'd0, int_req}, 8'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("b_isr2", {6'd0, state_dbg}, 8'd2);
    reti = 1'b1; reti_en = 1'b0;
    step();
    reti = 1'b0;
    sei = 1'b1;
    chk("b_ret2", {6'd0, state_dbg}, 8'd3);
    step();
    sei = 1'b0;
    chk("retid_iflag", {7'd0, i_flag}, 8'd0);
    chk("retid_state", {6'd0, state_dbg}, 8'd0);
    chk("retid_err", {7'd0, err_reti}, 8'd1);

    // Reset while in ISR.
    intr = 1'b0;
    repeat (3) step();
    sei = 1'b1; intr = 1'b1;
    step();
    sei = 1'b0;
    repeat (3) step();
    chk("d_req", {7'd0, int_req}, 8'd1);
    int_ack = 1'b1; c_in = 1'b1; z_in = 1'b1;
    step();
    int_ack = 1'b0; c_in = 1'b0; z_in = 1'b0;
    chk("d_isr", {5'd0, in_isr, shad_c, shad_z}, 8'b111);
    #2;
    clr_n = 1'b0;
    #1;
    chk("d_async_outs", outs(), 8'h00);
    chk("d_async_state", {6'd0, state_dbg}, 8'd0);
    intr = 1'b0;
    repeat (2) step();
    clr_n = 1'b1;
    step();
    chk("d_post_outs", outs(), 8'h00);
    chk("d_post_sel", {7'd0, flg_ld_sel}, 8'd0);
    step();
    chk("d_post_state", {6'd0, state_dbg}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
